// File: rtl/simon_disp_pkg.sv
// simon_disp_pkg: shared glyph geometry, 3x5 digit font table and color constants.
// Contents: GLYPH_W/GLYPH_H (glyph size), CELL_W/CELL_H (glyph cell incl. spacing),
//           FONT (digits 0-9, 15 bits each, row 0 in the MSBs, MSB of a row = left pixel),
//           BLACK/WHITE colors, font_row() lookup returning blank outside digits 0-9 / rows 0-4.
package simon_disp_pkg;
  localparam int GLYPH_W = 3;
  localparam int GLYPH_H = 5;
  localparam int CELL_W = 4;
  localparam int CELL_H = 6;
  localparam logic [2:0] BLACK = 3'd0;
  localparam logic [2:0] WHITE = 3'd7;
  localparam logic [0:9][14:0] FONT = {
    15'b111_101_101_101_111,
    15'b010_110_010_010_111,
    15'b111_001_111_100_111,
    15'b111_001_111_001_111,
    15'b101_101_111_001_001,
    15'b111_100_111_001_111,
    15'b111_100_111_101_111,
    15'b111_001_001_001_001,
    15'b111_101_111_101_111,
    15'b111_101_111_001_111
  };
  function automatic logic [2:0] font_row(input logic [3:0] n, input logic [2:0] r);
    logic [14:0] g;
    g = n > 4'd9 ? '0 : FONT[n];
    return r == 3'd0 ? g[14:12] :
           r == 3'd1 ? g[11:9] :
           r == 3'd2 ? g[8:6] :
           r == 3'd3 ? g[5:3] :
           r == 3'd4 ? g[2:0] : 3'b000;
  endfunction
endpackage

// File: rtl/digit_font_rom.sv
// digit_font_rom: combinational 3x5 digit font lookup.
// Ports: nibble (BCD digit), row (glyph row) -> pattern (3 pixels, MSB left); blank for nibble > 9 or row > 4.
module digit_font_rom
  import simon_disp_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic [2:0] row,
  output logic [2:0] pattern
);
  assign pattern = font_row(nibble, row);
endmodule

// File: rtl/score_overlay.sv
// score_overlay: 2-stage pixel pipeline overlaying BCD numeric fields on a video stream.
// Ports: clk, rst_n (async active-low), xvga/yvga/pix_valid (pixel in), frame_start (frame pulse),
//        fields_bcd/blink_mask (sampled on frame_start), bg (background) -> color/color_valid (2 cycles later).
// Build option: define SCORE_OVERLAY_BLINK_EN to enable per-field blinking; otherwise blink_mask is ignored.
module score_overlay
  import simon_disp_pkg::*;
#(
  parameter int NUM_FIELDS = 2,
  parameter int DIGITS = 2,
  parameter int X_W = 9,
  parameter int Y_W = 8,
  parameter int COLOR_W = 3,
  parameter int ORIGIN_X = 73,
  parameter int ORIGIN_Y = 5,
  parameter int FIELD_PITCH = 16,
  parameter logic [COLOR_W-1:0] FG_COLOR = 3'b111,
  parameter int BLINK_FRAMES = 30
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [X_W-1:0]               xvga,
  input  logic [Y_W-1:0]               yvga,
  input  logic                         pix_valid,
  input  logic                         frame_start,
  input  logic [NUM_FIELDS*DIGITS*4-1:0] fields_bcd,
  input  logic [NUM_FIELDS-1:0]        blink_mask,
  input  logic [COLOR_W-1:0]           bg,
  output logic [COLOR_W-1:0]           color,
  output logic                         color_valid
);
  // two spare bits keep cell origins near the right edge from wrapping
  localparam int CW = (X_W > Y_W ? X_W : Y_W) + 2;
  logic [NUM_FIELDS*DIGITS*4-1:0] sh_bcd;
  logic [NUM_FIELDS-1:0] field_off;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sh_bcd <= '0;
    else if (frame_start) sh_bcd <= fields_bcd;
`ifdef SCORE_OVERLAY_BLINK_EN
  localparam int CNT_W = BLINK_FRAMES > 1 ? $clog2(BLINK_FRAMES) : 1;
  logic [CNT_W-1:0] blink_cnt;
  logic blink_phase;
  logic [NUM_FIELDS-1:0] sh_mask;
  logic wrap;
  assign wrap = blink_cnt == CNT_W'(BLINK_FRAMES - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      blink_cnt <= '0;
      blink_phase <= 1'b0;
      sh_mask <= '0;
    end else if (frame_start) begin
      blink_cnt <= wrap ? '0 : blink_cnt + 1'b1;
      blink_phase <= blink_phase ^ wrap;
      sh_mask <= blink_mask;
    end
  assign field_off = blink_phase ? sh_mask : '0;
`else
  logic unused_mask;
  assign unused_mask = ^blink_mask;
  assign field_off = '0;
`endif
  logic [CW-1:0] xw, yw, dy, cx, dx;
  logic hit, off;
  logic [3:0] nib;
  logic [1:0] col;
  assign xw = CW'(xvga);
  assign yw = CW'(yvga);
  assign dy = yw - CW'(ORIGIN_Y);
  // unsigned dx < CELL_W together with xw >= cx gives the in-cell column test
  always_comb begin
    hit = 1'b0;
    off = 1'b0;
    nib = 4'd0;
    col = 2'd0;
    cx = '0;
    dx = '0;
    for (int f = 0; f < NUM_FIELDS; f++)
      for (int d = 0; d < DIGITS; d++) begin
        cx = CW'(ORIGIN_X + f * FIELD_PITCH + (DIGITS - 1 - d) * CELL_W);
        dx = xw - cx;
        if (xw >= cx && dx < CW'(CELL_W) && yw >= CW'(ORIGIN_Y) && dy < CW'(CELL_H)) begin
          hit = 1'b1;
          off = field_off[f];
          nib = sh_bcd[(f * DIGITS + d) * 4 +: 4];
          col = dx[1:0];
        end
      end
  end
  logic s1_valid, s1_hit, s1_off;
  logic [3:0] s1_nib;
  logic [2:0] s1_row;
  logic [1:0] s1_col;
  logic [COLOR_W-1:0] s1_bg;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_hit <= 1'b0;
      s1_off <= 1'b0;
      s1_nib <= '0;
      s1_row <= '0;
      s1_col <= '0;
      s1_bg <= '0;
    end else begin
      s1_valid <= pix_valid;
      s1_hit <= hit;
      s1_off <= off;
      s1_nib <= nib;
      s1_row <= dy[2:0];
      s1_col <= col;
      s1_bg <= bg;
    end
  logic [2:0] pattern;
  logic [3:0] pat4;
  logic on;
  digit_font_rom u_rom (
    .nibble (s1_nib),
    .row    (s1_row),
    .pattern(pattern)
  );
  // column 3 maps to the appended zero, giving the blank spacing column
  assign pat4 = {pattern, 1'b0};
  assign on = s1_hit && !s1_off && pat4[2'd3 - s1_col];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      color <= '0;
      color_valid <= 1'b0;
    end else begin
      color <= !s1_valid ? '0 : on ? FG_COLOR : s1_bg;
      color_valid <= s1_valid;
    end
endmodule
